// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and shared types for the instruction-fetch slice.
// Optional feature macro used by this slice: FETCH_MISALIGN_CHECK_EN
// (misaligned-PC detection with a TRAP state in fetch_unit).
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN     = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
    logic                misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: valid/ready handshake carrying {pc, instr} from fetch to decode.
// With FETCH_MISALIGN_CHECK_EN defined an extra out_misaligned flag travels
// alongside the head entry.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            out_misaligned;

  modport master (
    output out_valid, out_instr, out_pc, out_misaligned,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_pc, out_misaligned,
    output out_ready
  );
`else

  modport master (
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
`endif

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: small in-order FIFO of fetched entries with synchronous flush.
// The head reads as all-zero whenever the buffer is empty, so downstream never
// sees stale storage contents.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: never pop empty, only push when room or a pop frees a slot
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  // Pointer and occupancy bookkeeping; flush beats any push/pop in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset because the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives instruction memory every cycle, buffers the
// returned instruction and presents {pc, instr} to decode over valid/ready.
// Redirects flush the buffer and reload the PC.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned PC pushes a NOP
// flagged as misaligned and parks the FSM in TRAP until a redirect).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    out_if
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_next;
  logic             push;
  logic             pop;
  logic             flush;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;

  // Arbitrate redirect vs. push and compute the next PC and FSM state
  always_comb begin
    pop            = (count != '0) && out_if.out_ready;
    flush          = redirect_valid;
    push           = 1'b0;
    pc_next        = pc;
    state_next     = state;
    wr_entry       = '0;
    wr_entry.pc    = XLEN_DEF'(pc);
    wr_entry.instr = imem_instr;

    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = RUN;
    end else if ((state == RUN) && ((count != FULL_CNT) || pop)) begin
      push = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) begin
        wr_entry.instr      = NOP_INSTR;
        wr_entry.misaligned = 1'b1;
        state_next          = TRAP;
      end else begin
        pc_next = pc + XLEN'(4);
      end
`else
      pc_next = pc + XLEN'(4);
`endif
    end
  end

  // PC and FSM state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head),
    .count (count)
  );

  assign imem_addr        = pc;
  assign out_if.out_valid = (count != '0);
  assign out_if.out_instr = head.instr;
  assign out_if.out_pc    = head.pc[XLEN-1:0];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_if.out_misaligned = head.misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = head.misaligned;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected {pc, instr} pairs are
// queued when a fetch sequence is started and compared as decode consumes them.
// Honours FETCH_MISALIGN_CHECK_EN when defined.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  fetch_unit_if #(.XLEN(XLEN)) fu_if ();

  fetch_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (64'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_if         (fu_if)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Memory contents: word k holds (k+1)*0x11111111, upper address bits folded in
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] idx;
    logic [31:0] hi;
    idx = a[33:2];
    hi  = a[63:32];
    return ((idx + 32'd1) * 32'h1111_1111) ^ hi;
  endfunction

  // Combinational instruction memory model
  assign imem_instr = mem_word(imem_addr);

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_seq(input logic [63:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 64'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fu_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b, expected 0", fu_if.out_valid);
    end
    vectors++;
    if (fu_if.out_pc !== 64'h0 || fu_if.out_instr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got pc=%h instr=%h, expected pc=0 instr=0",
               fu_if.out_pc, fu_if.out_instr);
    end
    vectors++;
    if (imem_addr !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %h, expected 0", imem_addr);
    end
  endtask

  task automatic test_stream();
    exp_t e;
    fu_if.out_ready = 1'b1;
    apply_reset();
    exp_q.delete();
    expect_seq(64'h0, 4);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_latency: got valid=%b, expected 0", fu_if.out_valid);
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL stream: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    fu_if.out_ready = 1'b0;
    apply_reset();
    repeat (5) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== 64'h0 || imem_addr !== 64'h8) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b pc=%h addr=%h, expected valid=1 pc=0 addr=8",
                 i, fu_if.out_valid, fu_if.out_pc, imem_addr);
      end
    end
    exp_q.delete();
    expect_seq(64'h0, 5);
    fu_if.out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL backpressure_drain: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_flush();
    exp_t e;
    fu_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_prefull: got valid=%b, expected 1", fu_if.out_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    expect_seq(64'h100, 3);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0 || fu_if.out_pc !== 64'h0 || fu_if.out_instr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: got valid=%b pc=%h instr=%h, expected valid=0 pc=0 instr=0",
               fu_if.out_valid, fu_if.out_pc, fu_if.out_instr);
    end
    fu_if.out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL flush_resume: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    expect_seq(64'hFFFF_FFFF_FFFF_FFFC, 3);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_gap: got valid=%b, expected 0", fu_if.out_valid);
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL wrap: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    @(posedge clk); #1;
    redirect_pc    = 64'h400;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    expect_seq(64'h400, 3);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: got valid=%b, expected 0", fu_if.out_valid);
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL b2b: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    fu_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (fu_if.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_pre: got valid=%b, expected 1", fu_if.out_valid);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (fu_if.out_valid !== 1'b0 || fu_if.out_pc !== 64'h0 || fu_if.out_instr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async: got valid=%b pc=%h instr=%h, expected valid=0 pc=0 instr=0",
               fu_if.out_valid, fu_if.out_pc, fu_if.out_instr);
    end
    vectors++;
    if (imem_addr !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_addr: got %h, expected 0", imem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    fu_if.out_ready = 1'b1;
    exp_q.delete();
    expect_seq(64'h0, 3);
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_gap: got valid=%b, expected 0", fu_if.out_valid);
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL midreset_restart: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    fu_if.out_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misalign_gap: got valid=%b, expected 0", fu_if.out_valid);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    vectors++;
    if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== 64'h102 ||
        fu_if.out_instr !== NOP_INSTR || fu_if.out_misaligned !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL misalign_entry: got valid=%b pc=%h instr=%h mis=%b, expected valid=1 pc=102 instr=%h mis=1",
               fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, fu_if.out_misaligned, NOP_INSTR);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (fu_if.out_valid !== 1'b0 || imem_addr !== 64'h102) begin
        miscompares++;
        $display("[TB] FAIL misalign_trap[%0d]: got valid=%b addr=%h, expected valid=0 addr=102",
                 i, fu_if.out_valid, imem_addr);
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    expect_seq(64'h200, 2);
    @(negedge clk);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc ||
          fu_if.out_instr !== e.instr || fu_if.out_misaligned !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL misalign_resume: got valid=%b pc=%h instr=%h mis=%b, expected valid=1 pc=%h instr=%h mis=0",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, fu_if.out_misaligned, e.pc, e.instr);
      end
    end
`else
    exp_q.delete();
    expect_seq(64'h102, 3);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (fu_if.out_valid !== 1'b1 || fu_if.out_pc !== e.pc || fu_if.out_instr !== e.instr) begin
        miscompares++;
        $display("[TB] FAIL unaligned_fetch: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                 fu_if.out_valid, fu_if.out_pc, fu_if.out_instr, e.pc, e.instr);
      end
    end
`endif
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of instruction_memory.
- Owns the PC and drives the memory's byte address every cycle.
- Captures the combinational 32-bit instruction into a small in-order buffer, then hands {pc, instr} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump resolve) that flush buffered work and reload the PC.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_addr  out  XLEN  byte address to instruction memory; always equals the current PC.
- imem_instr  in  32  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  XLEN  new PC when redirect_valid=1.
- out_valid  out  1  buffer head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (reset=0, async) forces:
  - pc=RESET_PC, count=0, rd/wr pointers=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0.
  - This applies at any time, including mid-operation; all buffered entries are lost.
- imem_addr is combinational from pc.
- pop = out_valid & out_ready.
- push = (state==RUN) & !redirect_valid & (count<BUF_DEPTH | pop).
  - On push: write {pc, imem_instr} at wr pointer and set pc <= pc+4 (mod 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
  - When no push occurs, pc holds.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1 at the earliest.
- Throughput: 1 instruction/cycle when out_ready=1 continuously.
- Full buffer with pop in the same cycle: push and pop both occur; count is unchanged.
- Full buffer without pop: no push; pc stalls; imem_addr is stable.
- Empty buffer: out_valid=0 and out_instr/out_pc read 0. Never bypass memory to output in the same cycle.
- Redirect has priority over everything:
  - The buffer is flushed (count=0, pointers reset) and pc <= redirect_pc.
  - No push occurs in that cycle. A simultaneous pop is still observed by decode, but the count update is the flush.
  - state <= RUN.
  - The first post-redirect instruction appears 2 cycles after redirect_valid is sampled.
- Consecutive redirects: the last one wins; each flushes.
- FSM states: RUN (fetching), TRAP (fetching stopped; only reachable with the optional feature). TRAP -> RUN only on redirect or reset.
- Pointers wrap modulo BUF_DEPTH. count has width clog2(BUF_DEPTH)+1.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro:
  - Extra output port out_misaligned (1 bit, reset 0), travelling with the head entry.
  - If pc[1:0]!=0 when a push would occur: push {pc, 32'h00000013 (NOP)} with the misaligned flag set, do not increment pc, and state <= TRAP.
  - No further pushes until a redirect.
- Without the macro:
  - No out_misaligned port and no TRAP state.
  - pc low bits are unchecked; memory returns whatever bytes sit at the unaligned address.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN_DEF=64, ILEN=32, NOP_INSTR=32'h00000013.
  - The fetch state enum {RUN, TRAP}.
  - The fetch buffer entry struct {pc, instr, misaligned}.
- One natural sub-module: fetch_buffer. It is a parameterised synchronous FIFO with flush, push/pop and count, using the same clk/reset convention.
- fetch_unit keeps the PC, the FSM and the push/redirect arbitration.

Test Plan:
- Release reset with RESET_PC=0, out_ready=1, memory pre-loaded with 0x11111111, 0x22222222... -> out_valid rises the cycle after release; out_pc 0,4,8 on consecutive cycles with the matching instructions.
- out_ready=0 for 5 cycles after the first fetch -> buffer fills to 2; imem_addr frozen at 8. out_ready=1 -> entries pc=0,4 drain in order, then 8, with no gap or duplicate.
- Redirect to 0x100 while the buffer is full -> next cycle out_valid=0; cycle after, out_pc=0x100; stale pc=4/8 entries never appear.
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC -> sequence FFF..FFC then 0x0 (wrap).
- Assert reset mid-stream with the buffer non-empty -> out_valid=0 immediately (asynchronous, no clock edge needed); PC restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> one entry with out_pc=0x102, out_instr=0x00000013, out_misaligned=1, then no further entries. A redirect to 0x200 resumes fetching.
